wide_reg_atomic: RTL and testbench

WIDE_REG_ATOMIC -- requirements
Module: wide_reg_atomic

---
 rtl/wide_reg_pkg.sv | 13 +
 rtl/wide_reg_rdlatch.sv | 42 ++++
 rtl/wide_reg_atomic.sv | 114 +++++++++++
 tb/tb_wide_reg_atomic.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/wide_reg_pkg.sv
// Shared constants and helpers for the wide atomic register block.
package wide_reg_pkg;

  localparam int WORD_W = 32;

  // Width of the word-offset address: at least one bit even for tiny registers.
  function automatic int calc_aw(input int words);
    int aw;
    aw = $clog2(words);
    return (aw < 1) ? 1 : aw;
  endfunction

endpackage

// File: rtl/wide_reg_rdlatch.sv
// Read snapshot latch and read mux for the wide register status readback.
// A read of offset 0 returns the live MSW and captures the remaining words so
// later reads of the lower offsets see one coherent snapshot.
module wide_reg_rdlatch
  import wide_reg_pkg::*;
#(
  parameter int WORDS = 2,
  localparam int AW = calc_aw(WORDS)
) (
  input  logic                    Clk,
  input  logic                    Rst,
  input  logic                    rd,
  input  logic [AW-1:0]           addr,
  input  logic [WORDS*WORD_W-1:0] status,
  output logic [WORD_W-1:0]       rd_word
);

  // Only the lower words need storing; word 0 is returned live on the capturing read.
  logic [(WORDS-1)*WORD_W-1:0] latch;

  // Capture the status snapshot on every read of offset 0.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      latch <= '0;
    end else if (rd && (addr == '0)) begin
      latch <= status[(WORDS-1)*WORD_W-1:0];
    end
  end

  // Select the requested word; offsets beyond the register read as zero.
  always_comb begin
    rd_word = '0;
    if (addr == '0) begin
      rd_word = status[WORDS*WORD_W-1 -: WORD_W];
    end else begin
      for (int k = 1; k < WORDS; k++) begin
        if (int'(addr) == k) rd_word = latch[(WORDS-1-k)*WORD_W +: WORD_W];
      end
    end
  end

endmodule

// File: rtl/wide_reg_atomic.sv
// Wide register with atomic commit over a 32-bit VME-style bus.
// Lower words (offsets 1..WORDS-1) are staged in shadow registers; a write to
// offset 0 commits the whole register in a single cycle. Word order is
// big-endian (offset 0 is the MSW).
// Optional feature: define WIDE_REG_ATOMIC_READBACK_EN to enable status
// readback of reg_i through a snapshot latch; otherwise reads return 0.
module wide_reg_atomic
  import wide_reg_pkg::*;
#(
  parameter int WORDS = 2,
  parameter int PULSE = 0,
  localparam int AW = calc_aw(WORDS)
) (
  input  logic                    Clk,
  input  logic                    Rst,
  input  logic [AW+1:2]           VMEAddr,
  output logic [WORD_W-1:0]       VMERdData,
  input  logic [WORD_W-1:0]       VMEWrData,
  input  logic                    VMERdMem,
  input  logic                    VMEWrMem,
  output logic                    VMERdDone,
  output logic                    VMEWrDone,
  output logic [WORDS*WORD_W-1:0] reg_o,
  output logic                    reg_wr_o,
  input  logic [WORDS*WORD_W-1:0] reg_i
);

  logic                    wr_s1;
  logic [AW-1:0]           waddr_s1;
  logic [WORD_W-1:0]       wdata_s1;
  logic [WORD_W-1:0]       shadow [1:WORDS-1];
  logic [WORDS*WORD_W-1:0] commit_val;
  logic                    commit;
  logic [WORD_W-1:0]       rd_word;

  assign commit = wr_s1 && (waddr_s1 == '0);

  // Register the write strobe, address and data before decoding.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      wr_s1    <= 1'b0;
      waddr_s1 <= '0;
      wdata_s1 <= '0;
    end else begin
      wr_s1    <= VMEWrMem;
      waddr_s1 <= VMEAddr;
      wdata_s1 <= VMEWrData;
    end
  end

  // Assemble the committed value: new MSW plus the staged lower words.
  always_comb begin
    commit_val = '0;
    commit_val[WORDS*WORD_W-1 -: WORD_W] = wdata_s1;
    for (int k = 1; k < WORDS; k++) begin
      commit_val[(WORDS-1-k)*WORD_W +: WORD_W] = shadow[k];
    end
  end

  // Stage lower words; out-of-range offsets match no shadow word and are dropped.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      for (int k = 1; k < WORDS; k++) shadow[k] <= '0;
    end else begin
      for (int k = 1; k < WORDS; k++) begin
        if (wr_s1 && (int'(waddr_s1) == k)) shadow[k] <= wdata_s1;
      end
    end
  end

  // Commit the full register, pulse reg_wr_o and acknowledge the write.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      reg_o     <= '0;
      reg_wr_o  <= 1'b0;
      VMEWrDone <= 1'b0;
    end else begin
      VMEWrDone <= wr_s1;
      reg_wr_o  <= commit;
      if (commit) begin
        reg_o <= commit_val;
      end else if (PULSE != 0) begin
        reg_o <= '0;
      end
    end
  end

`ifdef WIDE_REG_ATOMIC_READBACK_EN
  wide_reg_rdlatch #(.WORDS(WORDS)) u_rdlatch (
    .Clk     (Clk),
    .Rst     (Rst),
    .rd      (VMERdMem),
    .addr    (VMEAddr),
    .status  (reg_i),
    .rd_word (rd_word)
  );
`else
  logic unused_reg_i;
  assign unused_reg_i = ^reg_i;
  assign rd_word      = '0;
`endif

  // Acknowledge reads one cycle after the strobe; data holds between reads.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      VMERdDone <= 1'b0;
      VMERdData <= '0;
    end else begin
      VMERdDone <= VMERdMem;
      if (VMERdMem) VMERdData <= rd_word;
    end
  end

endmodule

// File: tb/tb_wide_reg_atomic.sv
// Scoreboard bench for wide_reg_atomic: a WORDS=3 hold-mode instance driven by
// directed and random bus traffic, plus a WORDS=2 pulse-mode instance.
module tb_wide_reg_atomic;

  localparam int W  = 3;
  localparam int AW = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic            rst;
  logic [AW+1:2]   addr;
  logic [31:0]     wdata;
  logic            rd, wr;
  logic [31:0]     rdata;
  logic            rd_done, wr_done;
  logic [W*32-1:0] reg_o;
  logic            reg_wr;
  logic [W*32-1:0] reg_i;

  logic [2:2]      addr2;
  logic [31:0]     wdata2, rdata2;
  logic            rd2, wr2, rd_done2, wr_done2, reg_wr2;
  logic [63:0]     reg_o2, reg_i2;

  wide_reg_atomic #(.WORDS(W), .PULSE(0)) dut (
    .Clk(clk), .Rst(rst), .VMEAddr(addr), .VMERdData(rdata), .VMEWrData(wdata),
    .VMERdMem(rd), .VMEWrMem(wr), .VMERdDone(rd_done), .VMEWrDone(wr_done),
    .reg_o(reg_o), .reg_wr_o(reg_wr), .reg_i(reg_i)
  );

  wide_reg_atomic #(.WORDS(2), .PULSE(1)) dut_pulse (
    .Clk(clk), .Rst(rst), .VMEAddr(addr2), .VMERdData(rdata2), .VMEWrData(wdata2),
    .VMERdMem(rd2), .VMEWrMem(wr2), .VMERdDone(rd_done2), .VMEWrDone(wr_done2),
    .reg_o(reg_o2), .reg_wr_o(reg_wr2), .reg_i(reg_i2)
  );

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic void chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endfunction

  // Reference model: architectural words, index 0 = MSW.
  logic [31:0] m_shadow [W];
  logic [31:0] m_reg    [W];
  logic [31:0] m_snap   [W];

  typedef struct { int cyc; logic [W*32-1:0] val; logic commit; } wr_exp_t;
  typedef struct { int cyc; logic [31:0] data; } rd_exp_t;
  wr_exp_t wq[$];
  rd_exp_t rq[$];

  function automatic logic [W*32-1:0] pack_reg();
    logic [W*32-1:0] v;
    for (int k = 0; k < W; k++) v[(W-1-k)*32 +: 32] = m_reg[k];
    return v;
  endfunction

  task automatic model_clear();
    for (int k = 0; k < W; k++) begin
      m_shadow[k] = '0; m_reg[k] = '0; m_snap[k] = '0;
    end
    wq.delete();
    rq.delete();
  endtask

  // One bus cycle: drive strobes and push expected responses.
  task automatic issue(input bit w, input bit r, input int a, input logic [31:0] d,
                       input logic [W*32-1:0] st);
    wr_exp_t we;
    rd_exp_t re;
    @(posedge clk); #1;
    wr = w; rd = r; addr = a[AW-1:0]; wdata = d; reg_i = st;
    if (w) begin
      if (a < W) m_shadow[a] = d;
      if (a == 0) begin
        m_reg[0] = d;
        for (int k = 1; k < W; k++) m_reg[k] = m_shadow[k];
      end
      we.cyc = cyc + 2; we.val = pack_reg(); we.commit = (a == 0);
      wq.push_back(we);
    end
    if (r) begin
      re.data = '0;
`ifdef WIDE_REG_ATOMIC_READBACK_EN
      if (a == 0) for (int k = 0; k < W; k++) m_snap[k] = st[(W-1-k)*32 +: 32];
      if (a < W) re.data = m_snap[a];
`endif
      re.cyc = cyc + 1;
      rq.push_back(re);
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) issue(0, 0, 0, '0, reg_i);
  endtask

  // Monitor: pop and compare whenever the DUT acknowledges.
  logic [W*32-1:0] last_reg;
  logic [31:0]     last_rd;
  wr_exp_t         wm;
  rd_exp_t         rm;

  always @(negedge clk) begin
    if (rst) begin
      last_reg = '0;
      last_rd  = '0;
    end else begin
      if (wq.size() > 0 && wq[0].cyc < cyc) begin
        wm = wq.pop_front();
        chk("wr_done_missing", 1'b0, 1'b1);
      end
      if (wr_done) begin
        if (wq.size() == 0) begin
          chk("wr_done_unexpected", wr_done, 1'b0);
        end else begin
          wm = wq.pop_front();
          chk("wr_latency", cyc, wm.cyc);
          chk("wr_commit_pulse", reg_wr, wm.commit);
          last_reg = wm.val;
        end
      end else begin
        chk("wr_pulse_stray", reg_wr, 1'b0);
      end
      chk("reg_o", reg_o, last_reg);

      if (rq.size() > 0 && rq[0].cyc < cyc) begin
        rm = rq.pop_front();
        chk("rd_done_missing", 1'b0, 1'b1);
      end
      if (rd_done) begin
        if (rq.size() == 0) begin
          chk("rd_done_unexpected", rd_done, 1'b0);
        end else begin
          rm = rq.pop_front();
          chk("rd_latency", cyc, rm.cyc);
          chk("rd_data", rdata, rm.data);
          last_rd = rm.data;
        end
      end else begin
        chk("rd_data_hold", rdata, last_rd);
      end
    end
  end

  logic [W*32-1:0] st;
  int              n;

  initial begin
    rst = 1'b1; wr = 0; rd = 0; addr = '0; wdata = '0; reg_i = '0;
    wr2 = 0; rd2 = 0; addr2 = '0; wdata2 = '0; reg_i2 = 64'h0123_4567_89AB_CDEF;
    model_clear();
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_reg_o", reg_o, '0);
    chk("rst_rd_data", rdata, '0);
    chk("rst_dones", {rd_done, wr_done, reg_wr}, 3'b000);
    @(posedge clk); #1;
    rst = 1'b0;

    // Stage lower words, then commit; then reads including out-of-range.
    st = 96'h01234567_89ABCDEF_55AA55AA;
    issue(1, 0, 1, 32'h1111_1111, st);
    issue(1, 0, 2, 32'h3333_3333, st);
    idle(3);
    issue(1, 0, 0, 32'h2222_2222, st);
    issue(0, 1, 0, '0, st);
    issue(0, 0, 0, '0, 96'hFFFFFFFF_00000000_12341234);
    issue(0, 1, 1, '0, 96'hFFFFFFFF_00000000_12341234);
    issue(0, 1, 2, '0, st);
    issue(0, 1, 3, '0, st);
    issue(1, 0, 3, 32'hBAD0_BAD0, st);
    idle(3);
    issue(1, 1, 0, 32'h0000_000A, st);
    idle(4);

    // Random traffic with independent read/write strobes on a shared address.
    for (int i = 0; i < 400; i++) begin
      st = {$urandom, $urandom, $urandom};
      issue($urandom_range(0, 2) == 0, $urandom_range(0, 2) == 0,
            $urandom_range(0, 3), $urandom, st);
    end
    idle(4);

    // A commit in flight when reset arrives must vanish.
    issue(1, 0, 0, 32'h5A5A_5A5A, st);
    @(posedge clk); #1;
    wr = 0; rd = 0; rst = 1'b1;
    model_clear();
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    idle(5);
    chk("post_rst_reg_o", reg_o, '0);
    chk("queues_drained", wq.size() + rq.size(), 0);

    // Pulse-mode instance: each commit is visible for exactly one cycle.
    @(posedge clk); #1;
    wr2 = 1; addr2 = 1'b1; wdata2 = 32'hCAFE_F00D;
    @(posedge clk); #1;
    addr2 = 1'b0; wdata2 = 32'hDEAD_BEEF;
    @(posedge clk); #1;
    wr2 = 0;
    n = 0;
    @(negedge clk);
    while (!reg_wr2 && n < 6) begin @(negedge clk); n++; end
    chk("pulse_commit_seen", reg_wr2, 1'b1);
    chk("pulse_value", reg_o2, 64'hDEADBEEF_CAFEF00D);
    @(negedge clk);
    chk("pulse_clear", reg_o2, 64'h0);
    chk("pulse_wr_low", reg_wr2, 1'b0);

    @(posedge clk); #1;
    wr2 = 1; addr2 = 1'b0; wdata2 = 32'h1111_1111;
    @(posedge clk); #1;
    wdata2 = 32'h2222_2222;
    @(posedge clk); #1;
    wr2 = 0;
    n = 0;
    @(negedge clk);
    while (!reg_wr2 && n < 6) begin @(negedge clk); n++; end
    chk("b2b_first", reg_o2, 64'h11111111_CAFEF00D);
    @(negedge clk);
    chk("b2b_second", reg_o2, 64'h22222222_CAFEF00D);
    chk("b2b_second_pulse", reg_wr2, 1'b1);
    @(negedge clk);
    chk("b2b_clear", reg_o2, 64'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
